// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Decode-to-execute operand stage. Each accepted instruction drives its
// source indices onto the register-file read port, waits one cycle for the
// synchronous read data, and then presents the operands to execute through
// a valid/ready handshake.
//
// A 32-entry busy scoreboard records destinations that have been issued but
// not yet written back. Decode is stalled on RAW hazards (a used source is
// busy) and on WAW hazards (the destination is already busy). A writeback
// that lands on the same edge as an accept is forwarded through a per-source
// bypass register. The register file returns the old value in that case.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid / in_ready           decode handshake
//   in_rs1, in_rs2                source register indices
//   in_use_rs1, in_use_rs2        the corresponding source is actually read
//   in_rd, in_rd_wr               destination index and write enable
//   in_pc, in_ctrl                PC and opaque decoded control
//   rf_rs1, rf_rs2                register-file read addresses
//   rf_rs1_d, rf_rs2_d            register-file read data, one cycle later
//   wb_wr, wb_rd, wb_d            writeback port, shared with the file
//   out_valid / out_ready         execute handshake
//   out_rs1_d, out_rs2_d          operand values
//   out_rd, out_rd_wr             registered destination fields
//   out_pc, out_ctrl              registered PC and control
// ---------------------------------------------------------------------------
module operand_fetch #(
  parameter int unsigned CTRL_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_wr,
  input  logic [31:0]       in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,

  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic [31:0]       rf_rs1_d,
  input  logic [31:0]       rf_rs2_d,

  input  logic              wb_wr,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_d,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rs1_d,
  output logic [31:0]       out_rs2_d,
  output logic [4:0]        out_rd,
  output logic              out_rd_wr,
  output logic [31:0]       out_pc,
  output logic [CTRL_W-1:0] out_ctrl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no instruction held
    READ = 2'd1,  // register file is returning data this cycle
    HOLD = 2'd2   // operands valid towards execute
  } state_e;

  state_e state_q, state_d;

  // Scoreboard of destinations issued but not yet written back.
  logic [31:0] busy_q, busy_d;
  logic [31:0] wb_clr;
  logic [31:0] busy_eff;
  logic [31:0] busy_set;

  logic hazard;
  logic accept;

  // Instruction fields latched on accept.
  logic [4:0]        rs1_q, rs2_q;
  logic [4:0]        rd_q;
  logic              rd_wr_q;
  logic [31:0]       pc_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Same-edge writeback forwarding, one flagged register per source.
  logic        byp1_q, byp2_q;
  logic [31:0] byp1_val_q, byp2_val_q;

  // Operand registers and their next values.
  logic [31:0] op1_q, op2_q;
  logic [31:0] op1_d, op2_d;

  // -------------------------------------------------------------------------
  // Scoreboard and hazard detection
  // -------------------------------------------------------------------------
  // A writeback in the current cycle already resolves its register, so the
  // hazard check looks at the scoreboard with that clear applied.
  // NOTE: every signal written in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    wb_clr = '0;
    if (wb_wr && (wb_rd != 5'd0)) begin
      wb_clr[wb_rd] = 1'b1;
    end
  end

  assign busy_eff = busy_q & ~wb_clr;

  assign hazard = (in_use_rs1 && busy_eff[in_rs1]) ||
                  (in_use_rs2 && busy_eff[in_rs2]) ||
                  (in_rd_wr   && busy_eff[in_rd]);

  assign in_ready = ((state_q == IDLE) || ((state_q == HOLD) && out_ready)) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    busy_set = '0;
    if (accept && in_rd_wr && (in_rd != 5'd0)) begin
      busy_set[in_rd] = 1'b1;
    end
  end

  // The set is ORed in after the clear, so a set wins over a clear on the
  // same index. Entry 0 is forced low: x0 is never pending.
  assign busy_d = ((busy_q & ~wb_clr) | busy_set) & 32'hFFFF_FFFE;

  // -------------------------------------------------------------------------
  // Register-file addressing
  // -------------------------------------------------------------------------
  // The file samples its address on the accept edge, so the new indices go
  // out combinationally; otherwise the latched indices keep the port stable.
  assign rf_rs1 = accept ? in_rs1 : rs1_q;
  assign rf_rs2 = accept ? in_rs2 : rs2_q;

  // -------------------------------------------------------------------------
  // Operand selection in READ
  // -------------------------------------------------------------------------
  always_comb begin
    op1_d = rf_rs1_d;
    op2_d = rf_rs2_d;
    if (byp1_q) begin
      op1_d = byp1_val_q;
    end
    if (byp2_q) begin
      op2_d = byp2_val_q;
    end
    if (rs1_q == 5'd0) begin
      op1_d = '0;
    end
    if (rs2_q == 5'd0) begin
      op2_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready && accept) begin
          state_d = READ;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Instruction fields and bypass registers load on accept only. A held
  // instruction therefore keeps its out_* fields stable while execute stalls.
  // NOTE: the datapath registers are reset too, because they drive module
  // outputs directly and must read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rd_wr_q    <= 1'b0;
      pc_q       <= '0;
      ctrl_q     <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp1_val_q <= '0;
      byp2_val_q <= '0;
    end else if (accept) begin
      rs1_q      <= in_rs1;
      rs2_q      <= in_rs2;
      rd_q       <= in_rd;
      rd_wr_q    <= in_rd_wr;
      pc_q       <= in_pc;
      ctrl_q     <= in_ctrl;
      // The file returns the pre-write value when a writeback and a read of
      // the same register share an edge, so the new value is kept here.
      byp1_q     <= wb_wr && (wb_rd != 5'd0) && (wb_rd == in_rs1);
      byp2_q     <= wb_wr && (wb_rd != 5'd0) && (wb_rd == in_rs2);
      byp1_val_q <= wb_d;
      byp2_val_q <= wb_d;
    end
  end

  // Operands are captured once, in READ. No bypass is needed in HOLD: a held
  // source can never be written because it would have stalled as a RAW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
    end else if (state_q == READ) begin
      op1_q <= op1_d;
      op2_q <= op2_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid = (state_q == HOLD);
  assign out_rs1_d = op1_q;
  assign out_rs2_d = op2_q;
  assign out_rd    = rd_q;
  assign out_rd_wr = rd_wr_q;
  assign out_pc    = pc_q;
  assign out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//
// Scoreboard bench for operand_fetch. A driver applies one cycle of stimulus
// at a time, predicts in_ready / out_valid from a reference model (register
// values, pending-destination set, stage occupancy) and pushes the expected
// operand bundle on every accept. An independent monitor pops and compares
// whenever execute consumes, and checks that a stalled output stays stable.
// The environment contains a synchronous read-before-write register file.
// ---------------------------------------------------------------------------
module tb_operand_fetch;

  localparam int CTRL_W = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1, in_rs2;
  logic              in_use_rs1, in_use_rs2;
  logic [4:0]        in_rd;
  logic              in_rd_wr;
  logic [31:0]       in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        rf_rs1, rf_rs2;
  logic [31:0]       rf_rs1_d, rf_rs2_d;
  logic              wb_wr;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_d;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_rs1_d, out_rs2_d;
  logic [4:0]        out_rd;
  logic              out_rd_wr;
  logic [31:0]       out_pc;
  logic [CTRL_W-1:0] out_ctrl;

  operand_fetch #(.CTRL_W(CTRL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_use_rs1 (in_use_rs1),
    .in_use_rs2 (in_use_rs2),
    .in_rd      (in_rd),
    .in_rd_wr   (in_rd_wr),
    .in_pc      (in_pc),
    .in_ctrl    (in_ctrl),
    .rf_rs1     (rf_rs1),
    .rf_rs2     (rf_rs2),
    .rf_rs1_d   (rf_rs1_d),
    .rf_rs2_d   (rf_rs2_d),
    .wb_wr      (wb_wr),
    .wb_rd      (wb_rd),
    .wb_d       (wb_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs1_d  (out_rs1_d),
    .out_rs2_d  (out_rs2_d),
    .out_rd     (out_rd),
    .out_rd_wr  (out_rd_wr),
    .out_pc     (out_pc),
    .out_ctrl   (out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment register file: synchronous read, old data on a same-edge
  // write. Entry 0 holds junk so the stage's own zeroing of x0 is visible.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    rf_rs1_d <= rf_mem[rf_rs1];
    rf_rs2_d <= rf_mem[rf_rs2];
    if (wb_wr && (wb_rd != 5'd0)) rf_mem[wb_rd] <= wb_d;
  end

  typedef struct packed {
    logic              v;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              u1;
    logic              u2;
    logic [4:0]        rd;
    logic              wr;
    logic [31:0]       pc;
    logic [CTRL_W-1:0] ctrl;
    logic              wbw;
    logic [4:0]        wbr;
    logic [31:0]       wbd;
    logic              ordy;
  } stim_t;

  typedef struct packed {
    logic [31:0]       a;
    logic [31:0]       b;
    logic [4:0]        rd;
    logic              wr;
    logic [31:0]       pc;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  // Reference model state.
  exp_t        sbq[$];
  logic [31:0] rf_m [32];
  logic [31:0] busy_m;
  int          age;      // 0 empty, 1 reading, 2 operands offered
  int          n_vec;
  int          n_err;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle_stim(input logic ordy);
    stim_t s;
    s      = '0;
    s.ordy = ordy;
    return s;
  endfunction

  // Register r is still pending after this cycle's writeback is applied.
  function automatic logic pending(input logic [4:0] r, input stim_t s);
    return busy_m[r] && !(s.wbw && (s.wbr == r) && (r != 5'd0));
  endfunction

  // Architectural value of r as seen by an instruction accepted this edge.
  function automatic logic [31:0] opval(input logic [4:0] r, input stim_t s);
    if (r == 5'd0) return 32'h0;
    if (s.wbw && (s.wbr == r)) return s.wbd;
    return rf_m[r];
  endfunction

  task automatic step(input stim_t s);
    logic haz, exp_rdy, acc;
    exp_t e;
    @(negedge clk);
    in_valid   = s.v;
    in_rs1     = s.rs1;
    in_rs2     = s.rs2;
    in_use_rs1 = s.u1;
    in_use_rs2 = s.u2;
    in_rd      = s.rd;
    in_rd_wr   = s.wr;
    in_pc      = s.pc;
    in_ctrl    = s.ctrl;
    wb_wr      = s.wbw;
    wb_rd      = s.wbr;
    wb_d       = s.wbd;
    out_ready  = s.ordy;
    #1;
    haz     = (s.u1 && pending(s.rs1, s)) || (s.u2 && pending(s.rs2, s)) ||
              (s.wr && pending(s.rd, s));
    exp_rdy = ((age == 0) || ((age == 2) && s.ordy)) && !haz;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, age == 2);
    acc = s.v && in_ready;
    if (acc) begin
      e.a    = opval(s.rs1, s);
      e.b    = opval(s.rs2, s);
      e.rd   = s.rd;
      e.wr   = s.wr;
      e.pc   = s.pc;
      e.ctrl = s.ctrl;
      sbq.push_back(e);
    end
    @(posedge clk);
    if (s.wbw && (s.wbr != 5'd0)) begin
      rf_m[s.wbr]   = s.wbd;
      busy_m[s.wbr] = 1'b0;
    end
    if (acc && s.wr && (s.rd != 5'd0)) busy_m[s.rd] = 1'b1;
    if (acc) age = 1;
    else if (age == 1) age = 2;
    else if ((age == 2) && s.ordy) age = 0;
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    int    cands[$];
    s.v    = ($urandom_range(3) != 0);
    s.rs1  = 5'($urandom_range(7));
    s.rs2  = 5'($urandom_range(7));
    s.u1   = 1'($urandom_range(1));
    s.u2   = 1'($urandom_range(1));
    s.rd   = 5'($urandom_range(7));
    s.wr   = 1'($urandom_range(1));
    s.pc   = $urandom;
    s.ctrl = $urandom;
    s.ordy = ($urandom_range(9) < 7);
    s.wbw  = ($urandom_range(9) < 4);
    s.wbd  = $urandom;
    for (int i = 1; i < 32; i++) if (busy_m[i]) cands.push_back(i);
    if ((cands.size() > 0) && ($urandom_range(3) != 0))
      s.wbr = 5'(cands[$urandom_range(cands.size() - 1)]);
    else
      s.wbr = 5'($urandom_range(7));
    return s;
  endfunction

  // Monitor: consumes on out_valid && out_ready, checks stability otherwise.
  initial begin
    logic have;
    exp_t snap, cur, e;
    have = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        have = 1'b0;
      end else begin
        cur = {out_rs1_d, out_rs2_d, out_rd, out_rd_wr, out_pc, out_ctrl};
        if (have) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_stable", cur, snap);
        end
        have = 1'b0;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got pc %0h, expected no output", out_pc);
          end else begin
            e = sbq.pop_front();
            check("rs1_d", cur.a, e.a);
            check("rs2_d", cur.b, e.b);
            check("rd", {cur.rd, cur.wr}, {e.rd, e.wr});
            check("pc", cur.pc, e.pc);
            check("ctrl", cur.ctrl, e.ctrl);
          end
        end else if (out_valid) begin
          have = 1'b1;
          snap = cur;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    logic [31:0] v;
    rst_n = 1'b0;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd = 0; in_rd_wr = 0; in_pc = 0; in_ctrl = 0;
    wb_wr = 0; wb_rd = 0; wb_d = 0; out_ready = 0;
    n_vec = 0; n_err = 0; age = 0; busy_m = '0;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      rf_mem[i] = v;
      rf_m[i]   = v;
    end
    rf_mem[0] = 32'h0BAD_0000;
    rf_m[0]   = 32'h0;
    rf_mem[5] = 32'h0000_1234;
    rf_m[5]   = 32'h0000_1234;

    // Reset values.
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_rs", {out_rs1_d, out_rs2_d}, 64'h0);
    check("rst_out_fields", {out_rd, out_rd_wr, out_pc, out_ctrl}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain read of x5 with x0 as the second source.
    s = idle_stim(1'b1); s.v = 1; s.rs1 = 5; s.rs2 = 0; s.u1 = 1; s.u2 = 1;
    s.pc = 32'h100; s.ctrl = 32'hC0DE;
    step(s);
    repeat (3) step(idle_stim(1'b1));

    // RAW on x7 resolved by a same-edge writeback through the bypass.
    s = idle_stim(1'b1); s.v = 1; s.rd = 7; s.wr = 1; s.pc = 32'h200;
    step(s);
    s = idle_stim(1'b1); s.v = 1; s.rs1 = 7; s.u1 = 1; s.pc = 32'h204;
    repeat (4) step(s);
    s.wbw = 1; s.wbr = 7; s.wbd = 32'hDEAD_BEEF;
    step(s);
    repeat (3) step(idle_stim(1'b1));

    // Execute stalls for 5 cycles while x9 is written; new work is refused.
    s = idle_stim(1'b1); s.v = 1; s.rs1 = 9; s.rs2 = 5; s.u1 = 1; s.u2 = 1;
    s.rd = 10; s.wr = 1; s.pc = 32'h300; s.ctrl = 32'h1357_9BDF;
    step(s);
    step(idle_stim(1'b0));
    for (int i = 0; i < 5; i++) begin
      s = idle_stim(1'b0); s.v = 1; s.rs1 = 1; s.u1 = 1; s.pc = 32'h304;
      s.wbw = 1; s.wbr = 9; s.wbd = $urandom;
      step(s);
    end
    step(idle_stim(1'b1));
    s = idle_stim(1'b1); s.wbw = 1; s.wbr = 10; s.wbd = 32'hA5A5_0010;
    step(s);
    repeat (2) step(idle_stim(1'b1));

    // WAW on x3: the second writer waits, and x3 stays pending after it.
    s = idle_stim(1'b1); s.v = 1; s.rd = 3; s.wr = 1; s.pc = 32'h400;
    step(s);
    s = idle_stim(1'b1); s.v = 1; s.rd = 3; s.wr = 1; s.pc = 32'h404;
    repeat (3) step(s);
    s.wbw = 1; s.wbr = 3; s.wbd = 32'h0000_0333;
    step(s);
    s = idle_stim(1'b1); s.v = 1; s.rs1 = 3; s.u1 = 1; s.pc = 32'h408;
    repeat (3) step(s);
    s.wbw = 1; s.wbr = 3; s.wbd = 32'h0000_0334;
    step(s);
    repeat (3) step(idle_stim(1'b1));

    // Writes to x0 never mark anything pending; x0 always reads as zero.
    s = idle_stim(1'b1); s.v = 1; s.rd = 0; s.wr = 1; s.pc = 32'h500;
    step(s);
    s = idle_stim(1'b1); s.v = 1; s.rs1 = 0; s.u1 = 1; s.rd = 0; s.wr = 1; s.pc = 32'h504;
    repeat (2) step(idle_stim(1'b1));
    step(s);
    repeat (3) step(idle_stim(1'b1));
    check("x0_busy_model", busy_m, 32'h0);

    // Reset mid-operation drops the instruction and clears the scoreboard.
    s = idle_stim(1'b0); s.v = 1; s.rd = 6; s.wr = 1; s.pc = 32'h600;
    step(s);
    step(idle_stim(1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd6; in_use_rs1 = 1'b1; in_rd_wr = 1'b0;
    wb_wr = 1'b0; out_ready = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    sbq.delete();
    busy_m = '0;
    age = 0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Randomised traffic over a small register window to provoke hazards.
    for (int i = 0; i < 2000; i++) step(rnd_stim());

    // Drain, bounded.
    for (int i = 0; i < 10 && age != 0; i++) step(idle_stim(1'b1));
    check("drain_age", age, 0);
    check("drain_queue", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
